// File: rtl/alu_pkg.sv
// Shared opcodes, ALU control words and state encoding for the sequential ALU driver.
// Control word bit order from MSB: ex, nx, ey, ny, f, no.
package alu_pkg;

    localparam logic [3:0] OP_ZERO = 4'd0;
    localparam logic [3:0] OP_X    = 4'd1;
    localparam logic [3:0] OP_Y    = 4'd2;
    localparam logic [3:0] OP_NOTX = 4'd3;
    localparam logic [3:0] OP_ADD  = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd5;
    localparam logic [3:0] OP_AND  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
    localparam logic [3:0] OP_INCX = 4'd8;
    localparam logic [3:0] OP_DECX = 4'd9;
    localparam logic [3:0] OP_NEGX = 4'd10;
    localparam logic [3:0] OP_ONE  = 4'd11;
    localparam logic [3:0] OP_SHL  = 4'd12;

    localparam logic [5:0] CW_ZERO = 6'b000000;
    localparam logic [5:0] CW_X    = 6'b100100;
    localparam logic [5:0] CW_Y    = 6'b011000;
    localparam logic [5:0] CW_NOTX = 6'b100101;
    localparam logic [5:0] CW_ADD  = 6'b101010;
    localparam logic [5:0] CW_SUB  = 6'b111011;
    localparam logic [5:0] CW_AND  = 6'b101000;
    localparam logic [5:0] CW_OR   = 6'b111101;
    localparam logic [5:0] CW_INCX = 6'b110111;
    localparam logic [5:0] CW_DECX = 6'b100110;
    localparam logic [5:0] CW_NEGX = 6'b100111;
    localparam logic [5:0] CW_ONE  = 6'b010111;
    localparam logic [5:0] CW_SHL  = 6'b101010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational opcode to ALU control word table.
// Reserved opcodes fall through to the ZERO control word.
module alu_seq_decode
    import alu_pkg::*;
(
    input  logic [3:0] op,
    output logic [5:0] ctrl
);

    always_comb begin
        ctrl = CW_ZERO;
        case (op)
            OP_ZERO: ctrl = CW_ZERO;
            OP_X:    ctrl = CW_X;
            OP_Y:    ctrl = CW_Y;
            OP_NOTX: ctrl = CW_NOTX;
            OP_ADD:  ctrl = CW_ADD;
            OP_SUB:  ctrl = CW_SUB;
            OP_AND:  ctrl = CW_AND;
            OP_OR:   ctrl = CW_OR;
            OP_INCX: ctrl = CW_INCX;
            OP_DECX: ctrl = CW_DECX;
            OP_NEGX: ctrl = CW_NEGX;
            OP_ONE:  ctrl = CW_ONE;
            OP_SHL:  ctrl = CW_SHL;
            default: ctrl = CW_ZERO;
        endcase
    end

endmodule

// File: rtl/alu_seq.sv
// Sequencer driving an external combinational ALU: one pass per EXEC cycle,
// SHL iterates acc+acc cnt times; result and optional flags captured on the final pass.
module alu_seq
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [15:0] req_x,
    input  logic [15:0] req_y,
    input  logic [3:0]  req_cnt,
    input  logic        req_setflags,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic [5:0]  alu_c,
    output logic        alu_en_bar,
    input  logic [15:0] alu_val,
    input  logic        alu_z,
    input  logic        alu_lt,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        flag_z,
    output logic        flag_lt
);

    state_t      state, state_nxt;
    logic [3:0]  op_q;
    logic [3:0]  cnt_q;
    logic [15:0] x_q;
    logic [15:0] y_q;
    logic        setflags_q;
    logic [15:0] acc;
    logic [3:0]  passes;
    logic [5:0]  dec_c;
    logic        is_shl;
    logic        shl_zero;
    logic        final_pass;
    logic        accept;

    alu_seq_decode u_decode (
        .op   (op_q),
        .ctrl (dec_c)
    );

    assign is_shl     = (op_q == OP_SHL);
    assign shl_zero   = is_shl && (cnt_q == 4'd0);
    assign final_pass = (state == S_EXEC) && (passes == 4'd1);
    assign accept     = (state == S_IDLE) && req_valid && !rst;

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        alu_c      = CW_ZERO;
        alu_x      = 16'd0;
        alu_y      = 16'd0;
        alu_en_bar = 1'b1;
        case (state)
            S_IDLE: begin
                req_ready = 1'b1;
                if (accept)
                    state_nxt = S_EXEC;
            end
            S_EXEC: begin
                // SHL with a zero count degenerates to a single pass-through of X
                alu_c      = shl_zero ? CW_X : dec_c;
                alu_x      = is_shl ? acc : x_q;
                alu_y      = is_shl ? acc : y_q;
                alu_en_bar = !final_pass;
                if (final_pass)
                    state_nxt = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready)
                    state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            op_q       <= 4'd0;
            cnt_q      <= 4'd0;
            x_q        <= 16'd0;
            y_q        <= 16'd0;
            setflags_q <= 1'b0;
            acc        <= 16'd0;
            passes     <= 4'd0;
            rsp_data   <= 16'd0;
            flag_z     <= 1'b0;
            flag_lt    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q       <= req_op;
                cnt_q      <= req_cnt;
                x_q        <= req_x;
                y_q        <= req_y;
                setflags_q <= req_setflags;
                acc        <= req_x;
                passes     <= (req_op == OP_SHL && req_cnt != 4'd0) ? req_cnt : 4'd1;
            end
            if (state == S_EXEC) begin
                acc    <= alu_val;
                passes <= passes - 4'd1;
                if (final_pass) begin
                    rsp_data <= alu_val;
                    if (setflags_q) begin
                        flag_z  <= alu_z;
                        flag_lt <= alu_lt;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: external ALU model, scoreboard of expected responses and flags.
module tb_alu_seq;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [15:0] req_x;
    logic [15:0] req_y;
    logic [3:0]  req_cnt;
    logic        req_setflags;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic [5:0]  alu_c;
    logic        alu_en_bar;
    logic [15:0] alu_val;
    logic        alu_z;
    logic        alu_lt;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        flag_z;
    logic        flag_lt;

    alu_seq dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_op       (req_op),
        .req_x        (req_x),
        .req_y        (req_y),
        .req_cnt      (req_cnt),
        .req_setflags (req_setflags),
        .alu_x        (alu_x),
        .alu_y        (alu_y),
        .alu_c        (alu_c),
        .alu_en_bar   (alu_en_bar),
        .alu_val      (alu_val),
        .alu_z        (alu_z),
        .alu_lt       (alu_lt),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_data     (rsp_data),
        .flag_z       (flag_z),
        .flag_lt      (flag_lt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU: ex/ey gate operands, nx/ny invert, f picks add/and, no inverts result
    logic [15:0] m_x, m_y, m_o;
    always_comb begin
        m_x = alu_c[5] ? alu_x : 16'd0;
        if (alu_c[4]) m_x = ~m_x;
        m_y = alu_c[3] ? alu_y : 16'd0;
        if (alu_c[2]) m_y = ~m_y;
        m_o = alu_c[1] ? (m_x + m_y) : (m_x & m_y);
        if (alu_c[0]) m_o = ~m_o;
    end
    assign alu_val = m_o;
    assign alu_z   = (m_o == 16'd0);
    assign alu_lt  = m_o[15];

    typedef struct {
        logic [15:0] data;
        logic        z;
        logic        lt;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    logic mdl_z = 1'b0;
    logic mdl_lt = 1'b0;

    function automatic logic [15:0] ref_alu(input logic [3:0] op, input logic [15:0] x,
                                            input logic [15:0] y, input logic [3:0] cnt);
        case (op)
            4'd1:    return x;
            4'd2:    return y;
            4'd3:    return ~x;
            4'd4:    return x + y;
            4'd5:    return x - y;
            4'd6:    return x & y;
            4'd7:    return x | y;
            4'd8:    return x + 16'd1;
            4'd9:    return x - 16'd1;
            4'd10:   return 16'd0 - x;
            4'd11:   return 16'd1;
            4'd12:   return x << cnt;
            default: return 16'd0;
        endcase
    endfunction

    // Drive one request and return #1 after its accepting edge (cycle 1 of the operation)
    task automatic issue(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y,
                         input logic [3:0] cnt, input logic sf, input bit track);
        int guard;
        exp_t e;
        logic [15:0] r;
        guard = 0;
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_x = x; req_y = y; req_cnt = cnt; req_setflags = sf;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!req_ready) begin
            vectors++; miscompares++;
            $display("FAIL issue_timeout: req_ready=%0b required 1", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if (track) begin
            r = ref_alu(op, x, y, cnt);
            if (sf) begin
                mdl_z  = (r == 16'd0);
                mdl_lt = r[15];
            end
            e.data = r; e.z = mdl_z; e.lt = mdl_lt;
            sb.push_back(e);
        end
    endtask

    task automatic await_rsp(output int cyc, output int exec_n, output int en_low_n,
                             output int en_low_last);
        cyc = 1; exec_n = 0; en_low_n = 0; en_low_last = 0;
        while (!rsp_valid && cyc < 40) begin
            exec_n++;
            if (!alu_en_bar) begin
                en_low_n++;
                en_low_last = exec_n;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        if (!rsp_valid) begin
            vectors++; miscompares++;
            $display("FAIL rsp_timeout: rsp_valid=%0b required 1", rsp_valid);
        end
    endtask

    task automatic finish_rsp(input string name);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL %s_sb_empty: no expected entry", name);
        end else begin
            e = sb.pop_front();
            if (rsp_data !== e.data) begin
                miscompares++;
                $display("FAIL %s_data: got %h required %h", name, rsp_data, e.data);
            end
            vectors++;
            if (flag_z !== e.z || flag_lt !== e.lt) begin
                miscompares++;
                $display("FAIL %s_flags: got z=%b lt=%b required z=%b lt=%b",
                         name, flag_z, flag_lt, e.z, e.lt);
            end
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 1'b1; req_op = 4'd4; req_x = 16'd1; req_y = 16'd1;
        repeat (2) @(posedge clk);
        #1;
        req_valid = 1'b0;
        vectors++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 16'd0 ||
            flag_z !== 1'b0 || flag_lt !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: ready=%b valid=%b data=%h z=%b lt=%b required 1 0 0000 0 0",
                     req_ready, rsp_valid, rsp_data, flag_z, flag_lt);
        end
        vectors++;
        if (alu_c !== 6'd0 || alu_en_bar !== 1'b1 || alu_x !== 16'd0 || alu_y !== 16'd0) begin
            miscompares++;
            $display("FAIL reset_alu: c=%b en_bar=%b x=%h y=%h required 000000 1 0 0",
                     alu_c, alu_en_bar, alu_x, alu_y);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_ignore_valid: ready=%b valid=%b required 1 0", req_ready, rsp_valid);
        end
        mdl_z = 1'b0; mdl_lt = 1'b0;
    endtask

    task automatic test_add;
        int cyc, ex, el, ell;
        issue(4'd4, 16'h7FFF, 16'h0001, 4'd0, 1'b1, 1'b1);
        await_rsp(cyc, ex, el, ell);
        vectors++;
        if (cyc !== 2) begin
            miscompares++;
            $display("FAIL add_latency: cycle %0d required 2", cyc);
        end
        finish_rsp("add");
    endtask

    task automatic test_flags;
        int cyc, ex, el, ell;
        issue(4'd5, 16'd5, 16'd5, 4'd0, 1'b1, 1'b1);
        await_rsp(cyc, ex, el, ell);
        finish_rsp("sub");
        issue(4'd7, 16'h00F0, 16'h0F00, 4'd0, 1'b0, 1'b1);
        await_rsp(cyc, ex, el, ell);
        finish_rsp("or_noflags");
    endtask

    task automatic test_shl;
        int cyc, ex, el, ell;
        issue(4'd12, 16'h0003, 16'h0000, 4'd15, 1'b0, 1'b1);
        await_rsp(cyc, ex, el, ell);
        vectors++;
        if (ex !== 15 || el !== 1 || ell !== 15) begin
            miscompares++;
            $display("FAIL shl15_passes: exec=%0d en_low=%0d at=%0d required 15 1 15", ex, el, ell);
        end
        finish_rsp("shl15");
        issue(4'd12, 16'h1234, 16'h0000, 4'd0, 1'b0, 1'b1);
        vectors++;
        if (alu_c !== 6'b100100 || alu_x !== 16'h1234) begin
            miscompares++;
            $display("FAIL shl0_ctrl: c=%b x=%h required 100100 1234", alu_c, alu_x);
        end
        await_rsp(cyc, ex, el, ell);
        vectors++;
        if (cyc !== 2) begin
            miscompares++;
            $display("FAIL shl0_latency: cycle %0d required 2", cyc);
        end
        finish_rsp("shl0");
    endtask

    task automatic test_stall;
        int cyc, ex, el, ell;
        logic [15:0] held;
        issue(4'd4, 16'h1111, 16'h2222, 4'd0, 1'b0, 1'b1);
        await_rsp(cyc, ex, el, ell);
        held = sb.size() > 0 ? sb[0].data : 16'hxxxx;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = (i == 2);
            req_op = 4'd11;
            @(posedge clk);
            #1;
            vectors++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_data !== held) begin
                miscompares++;
                $display("FAIL stall_hold: valid=%b ready=%b data=%h required 1 0 %h",
                         rsp_valid, req_ready, rsp_data, held);
            end
        end
        req_valid = 1'b0;
        finish_rsp("stall");
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL stall_no_accept: valid=%b ready=%b required 0 1", rsp_valid, req_ready);
            end
        end
    endtask

    task automatic test_reset_mid;
        int cyc, ex, el, ell;
        issue(4'd12, 16'h0001, 16'h0000, 4'd8, 1'b1, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 16'd0 || flag_z !== 1'b0 ||
            flag_lt !== 1'b0 || alu_c !== 6'd0 || alu_en_bar !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset: ready=%b valid=%b data=%h z=%b lt=%b c=%b en_bar=%b required 1 0 0000 0 0 000000 1",
                     req_ready, rsp_valid, rsp_data, flag_z, flag_lt, alu_c, alu_en_bar);
        end
        mdl_z = 1'b0; mdl_lt = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (rsp_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL midreset_no_rsp: valid=%b required 0", rsp_valid);
            end
        end
        issue(4'd10, 16'h0001, 16'h0000, 4'd0, 1'b0, 1'b1);
        await_rsp(cyc, ex, el, ell);
        finish_rsp("negx");
    endtask

    task automatic test_sweep;
        int cyc, ex, el, ell;
        for (int op = 0; op < 16; op++) begin
            issue(4'(op), 16'h00A5, 16'h0F0F, 4'd3, 1'b1, 1'b1);
            await_rsp(cyc, ex, el, ell);
            finish_rsp($sformatf("sweep_op%0d", op));
        end
    endtask

    task automatic test_back_to_back;
        int acc_cyc[3];
        int k, got, cyc;
        bit fire;
        exp_t e;
        k = 0; got = 0; cyc = 0;
        rsp_ready = 1'b1;
        req_cnt = 4'd0; req_setflags = 1'b0;
        while ((k < 3 || got < 3) && cyc < 60) begin
            @(negedge clk);
            if (k < 3) begin
                req_valid = 1'b1; req_op = 4'd4;
                req_x = 16'(2 * k + 1); req_y = 16'(2 * k + 2);
            end else begin
                req_valid = 1'b0;
            end
            fire = req_valid && req_ready;
            @(posedge clk);
            cyc++;
            if (fire) begin
                e.data = 16'(4 * k + 3); e.z = mdl_z; e.lt = mdl_lt;
                sb.push_back(e);
                acc_cyc[k] = cyc;
                k++;
            end
            #1;
            if (rsp_valid) begin
                vectors++;
                e = sb.pop_front();
                if (rsp_data !== e.data) begin
                    miscompares++;
                    $display("FAIL b2b_data: got %h required %h", rsp_data, e.data);
                end
                got++;
            end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        vectors++;
        if (got !== 3 || k !== 3) begin
            miscompares++;
            $display("FAIL b2b_count: accepted %0d responded %0d required 3 3", k, got);
        end else begin
            vectors++;
            if (acc_cyc[1] - acc_cyc[0] !== 3 || acc_cyc[2] - acc_cyc[1] !== 3) begin
                miscompares++;
                $display("FAIL b2b_spacing: gaps %0d %0d required 3 3",
                         acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
            end
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_x = 16'd0; req_y = 16'd0;
        req_cnt = 4'd0; req_setflags = 1'b0; rsp_ready = 1'b0;
        test_reset();
        test_add();
        test_flags();
        test_shl();
        test_stall();
        test_sweep();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
